// File: rtl/ov5640_cv_pkg.sv
// Shared constants for the OV5640 CV front end: frame geometry defaults,
// BT.601-style luma coefficients (x256) and the frame-tracking FSM encoding.
package ov5640_cv_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int XW_DEF       = 10;
   localparam int YW_DEF       = 10;

   // Coefficients sum to 256, so the >>8 of a full-scale pixel lands on 255.
   localparam logic [7:0] COEF_R = 8'd77;
   localparam logic [7:0] COEF_G = 8'd150;
   localparam logic [7:0] COEF_B = 8'd29;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

endpackage

// File: rtl/ov5640_gray_tagger_if.sv
// Pixel stream bundle: RGB565 camera input side and tagged luma output side.
// master = upstream/stimulus end, slave = the tagger.
interface ov5640_gray_tagger_if #(
   parameter int XW = 10,
   parameter int YW = 10
) ();

   logic          in_vsync;
   logic          in_valid;
   logic [15:0]   in_rgb565;

   logic          out_valid;
   logic [7:0]    out_gray;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_sof;
   logic          out_eol;
   logic          out_eof;

   modport master (
      output in_vsync, in_valid, in_rgb565,
      input  out_valid, out_gray, out_x, out_y, out_sof, out_eol, out_eof
   );

   modport slave (
      input  in_vsync, in_valid, in_rgb565,
      output out_valid, out_gray, out_x, out_y, out_sof, out_eol, out_eof
   );

endinterface

// File: rtl/rgb565_to_gray.sv
// Two-stage RGB565 -> 8-bit luma pipeline. Stage 1 widens each channel to
// 8 bits and registers the three weighted products; stage 2 sums and drops
// the 8 fractional bits. gray holds its last value between valid pixels.
module rgb565_to_gray
   import ov5640_cv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [15:0] rgb,
   output logic        valid_out,
   output logic [7:0]  gray
);

   localparam int STAGES = 2;

   logic [STAGES:1] vld_pipe_q;
   logic [7:0]      r8, g8, b8;
   logic [15:0]     pr_d, pg_d, pb_d;
   logic [15:0]     pr_q, pg_q, pb_q;
   logic [16:0]     sum;
   logic [7:0]      gray_d, gray_q;

   // Replicate MSBs into the new LSBs so full-scale 5/6-bit maps to 255.
   assign r8   = {rgb[15:11], rgb[15:13]};
   assign g8   = {rgb[10:5],  rgb[10:9]};
   assign b8   = {rgb[4:0],   rgb[4:2]};
   assign pr_d = {8'd0, r8} * {8'd0, COEF_R};
   assign pg_d = {8'd0, g8} * {8'd0, COEF_G};
   assign pb_d = {8'd0, b8} * {8'd0, COEF_B};

   assign sum    = {1'b0, pr_q} + {1'b0, pg_q} + {1'b0, pb_q};
   assign gray_d = 8'(sum >> 8);

   // Valid shift register: one bit per pipeline stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe_q <= '0;
      else        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_in};
   end

   // Stage 1: weighted channel products, loaded only for real pixels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_q <= '0;
         pg_q <= '0;
         pb_q <= '0;
      end else if (valid_in) begin
         pr_q <= pr_d;
         pg_q <= pg_d;
         pb_q <= pb_d;
      end
   end

   // Stage 2: luma result, held while no pixel is leaving the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             gray_q <= '0;
      else if (vld_pipe_q[1]) gray_q <= gray_d;
   end

   assign valid_out = vld_pipe_q[STAGES];
   assign gray      = gray_q;

endmodule

// File: rtl/ov5640_gray_tagger.sv
// Frame tracker and tagger for the OV5640 RGB565 stream. Locks onto vsync,
// counts x/y over accepted pixels, converts to luma and emits each pixel with
// its coordinates and sof/eol/eof markers. Frames whose pixel count is not
// exactly H_ACTIVE*V_ACTIVE raise frame_err; good ones bump frame_cnt.
module ov5640_gray_tagger
   import ov5640_cv_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int XW       = XW_DEF,
   parameter int YW       = YW_DEF
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   ov5640_gray_tagger_if.slave  bus,
   output logic                 frame_err,
   output logic [7:0]           frame_cnt
);

   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          sof;
      logic          eol;
      logic          eof;
   } tag_t;

   state_t        state_q, state_d;
   logic          vs_q;
   logic          vs_rise;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          accept;
   logic          frame_good;
   tag_t          tag_d, t1_q, t2_q;
   logic          v1_q;
   logic          pix_valid;
   logic [7:0]    pix_gray;

   assign vs_rise = bus.in_vsync & ~vs_q;

   // Exactly H*V pixels leaves the counters parked at (0, V_ACTIVE).
   assign frame_good = (x_q == '0) && (y_q == Y_END) && !ovf_q;

   assign tag_d.x   = x_q;
   assign tag_d.y   = y_q;
   assign tag_d.sof = (x_q == '0) && (y_q == '0);
   assign tag_d.eol = (x_q == X_LAST);
   assign tag_d.eof = (x_q == X_LAST) && (y_q == Y_LAST);

   // State, counters, vsync history and frame bookkeeping registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         vs_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_q    <= bus.in_vsync;
         x_q     <= x_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state: frame lock, pixel acceptance, coordinate and frame checks.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (vs_rise) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (!bus.in_vsync) begin
               state_d = ST_ACTIVE;
               x_d     = '0;
               y_d     = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // A pixel coinciding with the closing vsync edge is dropped.
            if (vs_rise) begin
               state_d = ST_SYNC;
               if (frame_good) cnt_d = cnt_q + 8'd1;
               else            err_d = 1'b1;
            end else if (bus.in_valid) begin
               if (y_q == Y_END) begin
                  ovf_d = 1'b1;
               end else begin
                  accept = 1'b1;
                  if (x_q == X_LAST) begin
                     x_d = '0;
                     y_d = y_q + YW'(1);
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   rgb565_to_gray u_luma (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .valid_in  (accept),
      .rgb       (bus.in_rgb565),
      .valid_out (pix_valid),
      .gray      (pix_gray)
   );

   // Tag delay line matching the two luma stages; stage 2 holds between pixels.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v1_q <= 1'b0;
         t1_q <= '0;
         t2_q <= '0;
      end else begin
         v1_q <= accept;
         if (accept) t1_q <= tag_d;
         if (v1_q)   t2_q <= t1_q;
      end
   end

   assign bus.out_valid = pix_valid;
   assign bus.out_gray  = pix_gray;
   assign bus.out_x     = t2_q.x;
   assign bus.out_y     = t2_q.y;
   assign bus.out_sof   = t2_q.sof & pix_valid;
   assign bus.out_eol   = t2_q.eol & pix_valid;
   assign bus.out_eof   = t2_q.eof & pix_valid;
   assign frame_err     = err_q;
   assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_ov5640_gray_tagger.sv
// Directed bench for ov5640_gray_tagger on a reduced 8x6 frame.
module tb_ov5640_gray_tagger;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int XW = 10;
   localparam int YW = 10;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       frame_err;
   logic [7:0] frame_cnt;

   ov5640_gray_tagger_if #(.XW(XW), .YW(YW)) bus ();

   ov5640_gray_tagger #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int n_vec = 0;
   int n_err = 0;

   // Running totals seen on the output stream, sampled on the falling edge.
   int         m_v = 0, m_sof = 0, m_eol = 0, m_eof = 0, m_err = 0;
   int         m_gbad = 0, m_mkbad = 0;
   int         sof_x = -1, sof_y = -1, eof_x = -1, eof_y = -1;
   logic [7:0] exp_gray = 8'd76;

   always @(negedge sys_clk) begin
      if (bus.out_valid) begin
         m_v <= m_v + 1;
         if (bus.out_gray !== exp_gray) m_gbad <= m_gbad + 1;
         if (bus.out_sof) begin
            m_sof <= m_sof + 1;
            sof_x <= int'(bus.out_x);
            sof_y <= int'(bus.out_y);
         end
         if (bus.out_eol) m_eol <= m_eol + 1;
         if (bus.out_eof) begin
            m_eof <= m_eof + 1;
            eof_x <= int'(bus.out_x);
            eof_y <= int'(bus.out_y);
         end
      end else if (bus.out_sof || bus.out_eol || bus.out_eof) begin
         m_mkbad <= m_mkbad + 1;
      end
      if (frame_err) m_err <= m_err + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Vsync high for 3 cycles then low; closes any open frame, opens the next.
   task automatic vsync_pulse();
      bus.in_vsync = 1'b1;
      tick(3);
      bus.in_vsync = 1'b0;
      tick(3);
   endtask

   task automatic frame(input int lines, input int short_line);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
            bus.in_valid = 1'b1;
            tick();
         end
         bus.in_valid = 1'b0;
         tick();
      end
   endtask

   int b_v, b_sof, b_eol, b_eof, b_err, b_gbad;

   task automatic snap();
      b_v = m_v; b_sof = m_sof; b_eol = m_eol; b_eof = m_eof;
      b_err = m_err; b_gbad = m_gbad;
   endtask

   initial begin
      sys_rst_n     = 1'b0;
      bus.in_vsync  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_rgb565 = 16'h0000;
      tick(3);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_gray",  32'(bus.out_gray),  0);
      chk("rst_x",     32'(bus.out_x),     0);
      chk("rst_cnt",   32'(frame_cnt),     0);
      chk("rst_err",   32'(frame_err),     0);

      // 1: pixels before any vsync are ignored.
      sys_rst_n = 1'b1;
      tick(2);
      snap();
      bus.in_rgb565 = 16'hF800;
      bus.in_valid  = 1'b1;
      tick(10);
      bus.in_valid = 1'b0;
      tick(4);
      chk("pre_vs_valid", 32'(m_v - b_v),     0);
      chk("pre_vs_err",   32'(m_err - b_err), 0);
      chk("pre_vs_cnt",   32'(frame_cnt),     0);

      // 2: one full red frame.
      vsync_pulse();
      snap();
      frame(V, -1);
      tick(3);
      chk("full_nvalid", 32'(m_v - b_v),       32'(H * V));
      chk("full_gray",   32'(m_gbad - b_gbad), 0);
      chk("full_nsof",   32'(m_sof - b_sof),   1);
      chk("full_sof_xy", 32'(sof_x * 1000 + sof_y), 0);
      chk("full_neol",   32'(m_eol - b_eol),   32'(V));
      chk("full_neof",   32'(m_eof - b_eof),   1);
      chk("full_eof_xy", 32'(eof_x * 1000 + eof_y), 32'((H - 1) * 1000 + V - 1));
      chk("hold_gray",   32'(bus.out_gray),    76);
      chk("hold_x",      32'(bus.out_x),       32'(H - 1));
      chk("hold_y",      32'(bus.out_y),       32'(V - 1));
      chk("idle_sof",    32'(bus.out_sof),     0);
      vsync_pulse();
      chk("full_cnt",    32'(frame_cnt),       1);
      chk("full_err",    32'(m_err - b_err),   0);

      // 3: line 2 one pixel short.
      snap();
      frame(V, 2);
      vsync_pulse();
      chk("short_nvalid", 32'(m_v - b_v),     32'(H * V - 1));
      chk("short_err",    32'(m_err - b_err), 1);
      chk("short_cnt",    32'(frame_cnt),     1);

      // 4: one extra line; surplus pixels dropped, frame flagged.
      snap();
      frame(V + 1, -1);
      vsync_pulse();
      chk("long_nvalid", 32'(m_v - b_v),     32'(H * V));
      chk("long_err",    32'(m_err - b_err), 1);
      chk("long_cnt",    32'(frame_cnt),     1);

      // 5: back-to-back white / green / blue, latency 2.
      bus.in_valid  = 1'b1;
      bus.in_rgb565 = 16'hFFFF;
      tick();
      chk("lat1_valid", 32'(bus.out_valid), 0);
      bus.in_rgb565 = 16'h07E0;
      tick();
      chk("white_valid", 32'(bus.out_valid), 1);
      chk("white_gray",  32'(bus.out_gray),  255);
      chk("white_sof",   32'(bus.out_sof),   1);
      bus.in_rgb565 = 16'h001F;
      tick();
      chk("green_gray",  32'(bus.out_gray),  149);
      chk("green_x",     32'(bus.out_x),     1);
      bus.in_valid = 1'b0;
      tick();
      chk("blue_gray",   32'(bus.out_gray),  28);
      chk("blue_x",      32'(bus.out_x),     2);
      tick();
      chk("after_valid", 32'(bus.out_valid), 0);
      chk("after_hold",  32'(bus.out_gray),  28);
      snap();
      vsync_pulse();
      chk("few_err",     32'(m_err - b_err), 1);

      // 6: reset mid-line at (4,3).
      bus.in_rgb565 = 16'hF800;
      frame(3, -1);
      bus.in_valid = 1'b1;
      tick(6);
      sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_gray",  32'(bus.out_gray),  0);
      chk("mid_rst_xy",    32'({bus.out_x, bus.out_y}), 0);
      chk("mid_rst_cnt",   32'(frame_cnt),     0);
      tick(2);
      sys_rst_n = 1'b1;
      snap();
      tick(10);
      bus.in_valid = 1'b0;
      tick(3);
      chk("post_rst_quiet", 32'(m_v - b_v), 0);
      vsync_pulse();
      snap();
      frame(V, -1);
      vsync_pulse();
      chk("recov_nvalid", 32'(m_v - b_v),       32'(H * V));
      chk("recov_gray",   32'(m_gbad - b_gbad), 0);
      chk("recov_sof_xy", 32'(sof_x * 1000 + sof_y), 0);
      chk("recov_cnt",    32'(frame_cnt),       1);
      chk("recov_err",    32'(m_err - b_err),   0);
      chk("marker_gate",  32'(m_mkbad),         0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
